// File: rtl/branch_resolve_bht.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_bht
// Purpose  : ID-stage branch/trap/jump resolution with a 2-bit-counter BHT
//            for IF-stage direction prediction and branch statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_bht #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              id_valid,
    input  logic [PC_W-1:0]   id_pc,
    input  logic              id_pred_taken,
    input  logic [5:0]        op,
    input  logic [4:0]        rt_field,
    input  logic [5:0]        func,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic              exception,
    output logic              is_branch,
    output logic              trap_taken,
    output logic              mispredict,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mp_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
    localparam logic [5:0] c_OP_REGIMM  = 6'b000001;
    localparam logic [5:0] c_OP_J       = 6'b000010;
    localparam logic [5:0] c_OP_JAL     = 6'b000011;
    localparam logic [5:0] c_OP_BEQ     = 6'b000100;
    localparam logic [5:0] c_OP_BNE     = 6'b000101;
    localparam logic [5:0] c_OP_BLEZ    = 6'b000110;
    localparam logic [5:0] c_OP_BGTZ    = 6'b000111;
    localparam logic [5:0] c_FN_JR      = 6'b001000;
    localparam logic [5:0] c_FN_JALR    = 6'b001001;
    localparam logic [5:0] c_FN_TEQ     = 6'b110100;
    localparam logic [5:0] c_FN_TNE     = 6'b110110;
    localparam logic [4:0] c_RT_BLTZ    = 5'b00000;
    localparam logic [4:0] c_RT_BGEZ    = 5'b00001;

    logic [1:0]        r_bht [BHT_DEPTH];
    logic [STAT_W-1:0] r_br_count;
    logic [STAT_W-1:0] r_mp_count;

    logic [IDX_W-1:0]  w_if_idx;
    logic [IDX_W-1:0]  w_id_idx;
    logic              w_eq, w_neg, w_zero;
    logic              w_is_cond, w_taken;
    logic              w_is_trap, w_trap_cond;
    logic              w_is_jump;
    logic              w_train;
    logic              w_unused_pc_bits;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_id_idx = id_pc[IDX_W+1:2];
    assign w_unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                                id_pc[PC_W-1:IDX_W+2], id_pc[1:0]};

    // Signed compares against zero reduce to sign bit and zero detect.
    assign w_eq   = (data_in1 == data_in2);
    assign w_neg  = data_in1[DATA_W-1];
    assign w_zero = (data_in1 == '0);

    always_comb begin
        w_is_cond   = 1'b0;
        w_taken     = 1'b0;
        w_is_trap   = 1'b0;
        w_trap_cond = 1'b0;
        w_is_jump   = 1'b0;
        case (op)
            c_OP_BEQ:  begin w_is_cond = 1'b1; w_taken = w_eq;              end
            c_OP_BNE:  begin w_is_cond = 1'b1; w_taken = !w_eq;             end
            c_OP_BLEZ: begin w_is_cond = 1'b1; w_taken = w_neg || w_zero;   end
            c_OP_BGTZ: begin w_is_cond = 1'b1; w_taken = !w_neg && !w_zero; end
            c_OP_REGIMM: begin
                if (rt_field == c_RT_BGEZ) begin
                    w_is_cond = 1'b1;
                    w_taken   = !w_neg;
                end else if (rt_field == c_RT_BLTZ) begin
                    w_is_cond = 1'b1;
                    w_taken   = w_neg;
                end
            end
            c_OP_J, c_OP_JAL: w_is_jump = 1'b1;
            c_OP_SPECIAL: begin
                case (func)
                    c_FN_TEQ:  begin w_is_trap = 1'b1; w_trap_cond = w_eq;  end
                    c_FN_TNE:  begin w_is_trap = 1'b1; w_trap_cond = !w_eq; end
                    c_FN_JR, c_FN_JALR: w_is_jump = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        is_branch  = 1'b0;
        trap_taken = 1'b0;
        mispredict = 1'b0;
        if (rst && id_valid) begin
            if (exception) begin
                is_branch = 1'b1;
            end else if (w_is_cond) begin
                is_branch  = w_taken;
                mispredict = w_taken ^ id_pred_taken;
            end else if (w_is_trap) begin
                is_branch  = w_trap_cond;
                trap_taken = w_trap_cond;
            end else if (w_is_jump) begin
                is_branch = 1'b1;
            end
        end
    end

    // No bypass: a same-index update this cycle is seen only next cycle.
    assign if_pred_taken = rst && r_bht[w_if_idx][1];
    assign w_train       = id_valid && !exception && w_is_cond;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
            r_br_count <= '0;
            r_mp_count <= '0;
        end else if (w_train) begin
            if (w_taken) begin
                if (r_bht[w_id_idx] != 2'b11) r_bht[w_id_idx] <= r_bht[w_id_idx] + 2'd1;
            end else begin
                if (r_bht[w_id_idx] != 2'b00) r_bht[w_id_idx] <= r_bht[w_id_idx] - 2'd1;
            end
            r_br_count <= r_br_count + STAT_W'(1);
            if (w_taken ^ id_pred_taken) r_mp_count <= r_mp_count + STAT_W'(1);
        end
    end

    assign br_count = r_br_count;
    assign mp_count = r_mp_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_bht.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_bht
// Purpose  : Table-driven self-checking bench for branch_resolve_bht.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_bht;

    localparam int c_SW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       if_pc;
    logic              if_pred_taken;
    logic              id_valid;
    logic [31:0]       id_pc;
    logic              id_pred_taken;
    logic [5:0]        op;
    logic [4:0]        rt_field;
    logic [5:0]        func;
    logic [31:0]       data_in1;
    logic [31:0]       data_in2;
    logic              exception;
    logic              is_branch;
    logic              trap_taken;
    logic              mispredict;
    logic [c_SW-1:0]   br_count;
    logic [c_SW-1:0]   mp_count;

    branch_resolve_bht #(.DATA_W(32), .PC_W(32), .BHT_DEPTH(64), .STAT_W(c_SW)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .id_valid(id_valid), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
        .op(op), .rt_field(rt_field), .func(func),
        .data_in1(data_in1), .data_in2(data_in2), .exception(exception),
        .is_branch(is_branch), .trap_taken(trap_taken), .mispredict(mispredict),
        .br_count(br_count), .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        v, e, p;
        logic [5:0]  o;
        logic [4:0]  r;
        logic [5:0]  f;
        logic [31:0] a, b, pc;
        logic        eb, et, em, tr;
    } vec_t;

    typedef struct {
        logic br, trap, mp, pred;
    } exp_t;

    exp_t            exp_q[$];
    logic [1:0]      m_bht [64];
    logic [c_SW-1:0] m_br, m_mp;
    int              n_vec = 0;
    int              n_err = 0;

    function automatic vec_t mk(string nm, logic v, logic e, logic p, logic [5:0] o,
                                logic [4:0] r, logic [5:0] f, logic [31:0] a, logic [31:0] b,
                                logic eb, logic et, logic em, logic tr);
        vec_t x;
        x.nm = nm; x.v = v; x.e = e; x.p = p; x.o = o; x.r = r; x.f = f;
        x.a = a; x.b = b; x.pc = 32'h0; x.eb = eb; x.et = et; x.em = em; x.tr = tr;
        return x;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        m_br = '0;
        m_mp = '0;
    endtask

    // Drive at posedge+1, check combinational outputs before the next edge,
    // then check the trained state just after it.
    task automatic run_vec(vec_t x);
        exp_t ex, got;
        int   idx;
        idx = int'(x.pc[7:2]);
        id_valid = x.v; exception = x.e; id_pred_taken = x.p; op = x.o;
        rt_field = x.r; func = x.f; data_in1 = x.a; data_in2 = x.b;
        id_pc = x.pc; if_pc = x.pc;
        ex.br = x.eb; ex.trap = x.et; ex.mp = x.em; ex.pred = m_bht[idx][1];
        exp_q.push_back(ex);
        #3;
        got = exp_q.pop_front();
        chk({x.nm, ".is_branch"}, 32'(is_branch), 32'(got.br));
        chk({x.nm, ".trap_taken"}, 32'(trap_taken), 32'(got.trap));
        chk({x.nm, ".mispredict"}, 32'(mispredict), 32'(got.mp));
        chk({x.nm, ".pred_old"}, 32'(if_pred_taken), 32'(got.pred));
        if (x.tr) begin
            if (x.eb && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'd1;
            if (!x.eb && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'd1;
            m_br = m_br + 1'b1;
            if (x.em) m_mp = m_mp + 1'b1;
        end
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        chk({x.nm, ".br_count"}, 32'(br_count), 32'(m_br));
        chk({x.nm, ".mp_count"}, 32'(mp_count), 32'(m_mp));
        chk({x.nm, ".pred_new"}, 32'(if_pred_taken), 32'(m_bht[idx][1]));
    endtask

    function automatic vec_t beq_at(logic [31:0] pc, logic taken, logic pred);
        vec_t x;
        x = mk("beq_seq", 1, 0, pred, 6'h04, 5'h0, 6'h0, 32'd5, taken ? 32'd5 : 32'd6,
               taken, 0, taken ^ pred, 1);
        x.pc = pc;
        return x;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [c_SW-1:0] br_before;
        logic            seq_exp[7];

        tbl.push_back(mk("bgez_min",   1,0,0, 6'h01,5'h01,6'h00, 32'h8000_0000,32'h0,       0,0,0,1));
        tbl.push_back(mk("bltz_min",   1,0,0, 6'h01,5'h00,6'h00, 32'h8000_0000,32'h0,       1,0,1,1));
        tbl.push_back(mk("beq_t",      1,0,1, 6'h04,5'h00,6'h00, 32'd5,32'd5,               1,0,0,1));
        tbl.push_back(mk("beq_nt",     1,0,1, 6'h04,5'h00,6'h00, 32'd5,32'd6,               0,0,1,1));
        tbl.push_back(mk("bne_exc",    1,1,0, 6'h05,5'h00,6'h00, 32'd1,32'd2,               1,0,0,0));
        tbl.push_back(mk("bne_inval",  0,1,0, 6'h05,5'h00,6'h00, 32'd1,32'd2,               0,0,0,0));
        tbl.push_back(mk("blez_zero",  1,0,0, 6'h06,5'h00,6'h00, 32'd0,32'd0,               1,0,1,1));
        tbl.push_back(mk("blez_pos",   1,0,0, 6'h06,5'h00,6'h00, 32'd1,32'd0,               0,0,0,1));
        tbl.push_back(mk("blez_neg",   1,0,1, 6'h06,5'h00,6'h00, 32'hFFFF_FFFF,32'd0,       1,0,0,1));
        tbl.push_back(mk("bgtz_pos",   1,0,0, 6'h07,5'h00,6'h00, 32'd1,32'd0,               1,0,1,1));
        tbl.push_back(mk("bgtz_zero",  1,0,1, 6'h07,5'h00,6'h00, 32'd0,32'd0,               0,0,1,1));
        tbl.push_back(mk("bgtz_min",   1,0,0, 6'h07,5'h00,6'h00, 32'h8000_0000,32'd0,       0,0,0,1));
        tbl.push_back(mk("bgez_zero",  1,0,0, 6'h01,5'h01,6'h00, 32'd0,32'd0,               1,0,1,1));
        tbl.push_back(mk("regimm_oth", 1,0,0, 6'h01,5'h02,6'h00, 32'h8000_0000,32'd0,       0,0,0,0));
        tbl.push_back(mk("teq_t",      1,0,0, 6'h00,5'h00,6'h34, 32'd7,32'd7,               1,1,0,0));
        tbl.push_back(mk("tne_nt",     1,0,0, 6'h00,5'h00,6'h36, 32'd7,32'd7,               0,0,0,0));
        tbl.push_back(mk("tne_t",      1,0,0, 6'h00,5'h00,6'h36, 32'd7,32'd8,               1,1,0,0));
        tbl.push_back(mk("jr",         1,0,0, 6'h00,5'h00,6'h08, 32'd0,32'd0,               1,0,0,0));
        tbl.push_back(mk("jalr",       1,0,0, 6'h00,5'h00,6'h09, 32'd0,32'd0,               1,0,0,0));
        tbl.push_back(mk("j",          1,0,1, 6'h02,5'h00,6'h00, 32'd0,32'd0,               1,0,0,0));
        tbl.push_back(mk("jal",        1,0,0, 6'h03,5'h00,6'h00, 32'd0,32'd0,               1,0,0,0));
        tbl.push_back(mk("add",        1,0,1, 6'h00,5'h00,6'h20, 32'd3,32'd3,               0,0,0,0));

        rst = 1'b0; id_valid = 1'b1; exception = 1'b0; id_pred_taken = 1'b0;
        op = 6'h04; rt_field = 5'h0; func = 6'h0; data_in1 = 32'd5; data_in2 = 32'd5;
        id_pc = 32'h40; if_pc = 32'h40;
        model_reset();

        // Reset with a taken BEQ pending: outputs forced low, no training.
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst.is_branch", 32'(is_branch), 32'd0);
            chk("rst.pred", 32'(if_pred_taken), 32'd0);
        end
        rst = 1'b1;
        id_valid = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i * 4);
            #0.1;
            chk($sformatf("rst.pred_idx%0d", i), 32'(if_pred_taken), 32'd0);
        end
        chk("rst.br_count", 32'(br_count), 32'd0);
        chk("rst.mp_count", 32'(mp_count), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t x;
            x = tbl[i];
            x.pc = 32'h1000 + 32'(4 * (40 + i));
            run_vec(x);
        end

        // Saturation at pc 0x40: 3 taken then 4 not-taken.
        seq_exp = '{1, 1, 1, 1, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            run_vec(beq_at(32'h40, i < 3, 1'b0));
            chk($sformatf("sat.pred%0d", i), 32'(if_pred_taken), 32'(seq_exp[i]));
        end
        if_pc = 32'h140;
        #1;
        chk("alias.pred_140", 32'(if_pred_taken), 32'd0);
        run_vec(beq_at(32'h140, 1'b1, 1'b0));
        if_pc = 32'h40;
        #1;
        chk("alias.pred_40_a", 32'(if_pred_taken), 32'd0);
        run_vec(beq_at(32'h140, 1'b1, 1'b0));
        if_pc = 32'h40;
        #1;
        chk("alias.pred_40_b", 32'(if_pred_taken), 32'd1);
        @(posedge clk);
        #1;

        // Same-index read/update at 0x80: old value this cycle, new next.
        run_vec(beq_at(32'h80, 1'b1, 1'b0));
        chk("same_idx.new", 32'(if_pred_taken), 32'd1);

        br_before = m_br;
        for (int i = 0; i < 16; i++) run_vec(beq_at(32'h1C0, i[0], 1'b1));
        chk("wrap.br_count", 32'(br_count), 32'(br_before));

        // Mid-stream reset discards the pending update.
        id_valid = 1'b1; op = 6'h04; data_in1 = 32'd5; data_in2 = 32'd5;
        exception = 1'b0; id_pc = 32'h80; if_pc = 32'h80;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        id_valid = 1'b0;
        model_reset();
        #1;
        chk("midrst.pred_80", 32'(if_pred_taken), 32'd0);
        chk("midrst.br_count", 32'(br_count), 32'd0);
        chk("midrst.mp_count", 32'(mp_count), 32'd0);
        @(posedge clk);
        #1;
        run_vec(beq_at(32'h80, 1'b1, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- ID-stage branch resolution unit with an integrated Branch History Table (BHT) of 2-bit saturating counters.
- IF side: looks up a taken/not-taken prediction by PC.
- ID side: resolves conditional branches, traps and jumps with signed compares, flags mispredicts and trains the BHT.
- Keeps wrap-around statistics counters for performance monitoring. Sits between the IF PC mux and the ID/EX hazard/flush logic.

Parameters:
- DATA_W, 32, operand width for compares.
- PC_W, 32, program counter width.
- BHT_DEPTH, 64, number of BHT entries; power of 2, at least 2. IDX_W = log2(BHT_DEPTH).
- STAT_W, 32, width of statistics counters.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, reset: synchronous, active-low.
- if_pc, input, PC_W, fetch PC for prediction lookup.
- if_pred_taken, output, 1, predicted direction for if_pc.
- id_valid, input, 1, ID instruction valid (not bubble/stalled).
- id_pc, input, PC_W, PC of the ID instruction.
- id_pred_taken, input, 1, prediction made at fetch, carried down the pipe.
- op, input, 6, opcode.
- rt_field, input, 5, rt field, used for REGIMM decode.
- func, input, 6, function field.
- data_in1, input, DATA_W, forwarded rs value.
- data_in2, input, DATA_W, forwarded rt value.
- exception, input, 1, pending exception redirect.
- is_branch, output, 1, PC redirect required this cycle.
- trap_taken, output, 1, TEQ/TNE condition true.
- mispredict, output, 1, conditional branch outcome differs from id_pred_taken.
- br_count, output, STAT_W, resolved conditional branches.
- mp_count, output, STAT_W, mispredicted conditional branches.

Behaviour:
- **Index.** idx(pc) = pc[IDX_W+1:2]. if_pred_taken = MSB of bht[idx(if_pc)]. The lookup is combinational.
- **Read during update.** A same-index update in the same cycle returns the pre-update value. There is no bypass.
- **Decode.** All compares are signed two's complement over DATA_W.
  - BEQ 000100: in1==in2.
  - BNE 000101: in1!=in2.
  - BLEZ 000110: in1<=0.
  - BGTZ 000111: in1>0.
  - REGIMM 000001 with rt_field 00001 (BGEZ): in1>=0.
  - REGIMM 000001 with rt_field 00000 (BLTZ): in1<0.
  - Any other REGIMM rt_field is not a branch.
  - Traps: op 000000 with func 110100 (TEQ) is in1==in2; func 110110 (TNE) is in1!=in2.
  - Jumps: J 000010, JAL 000011, JR (000000/001000), JALR (000000/001001).
- **Priority** (combinational outputs):
  1. id_valid=0: is_branch, trap_taken and mispredict are all 0; exception is ignored.
  2. exception=1: is_branch=1, trap_taken=0, mispredict=0.
  3. Conditional branch: is_branch=taken; mispredict = taken XOR id_pred_taken.
  4. Trap: is_branch=cond, trap_taken=cond.
  5. Jump: is_branch=1.
  6. Otherwise all three outputs are 0.
- **Training.** On a rising edge with rst=1, only priority-3 cases update the BHT entry bht[idx(id_pc)].
  - If taken: increment, saturating at 11.
  - If not taken: decrement, saturating at 00.
  - Traps, jumps, exceptions and invalid cycles never update the BHT.
- **Statistics.** Same edge and condition as training: br_count += 1. If mispredict is also 1, mp_count += 1 in the same edge. Both counters wrap modulo 2^STAT_W.
- **Reset.** On a rising edge with rst=0:
  - all BHT entries go to 01 (weakly not-taken);
  - br_count = 0 and mp_count = 0;
  - no update occurs that edge.
  - Combinational outputs are forced to 0 while rst=0: if_pred_taken=0, is_branch=0, trap_taken=0, mispredict=0.
  - Reset mid-stream discards any training from the reset cycle.
- **Latency.** Resolution: 0 cycles (combinational). A training effect is visible on if_pred_taken the cycle after the update edge.

Test Plan:
1. **Reset.** Apply rst=0 for 2 cycles, then release.
   - Required: if_pred_taken=0 for all idx 0..63; br_count=0; mp_count=0.
2. **Signed compare.** BGEZ with in1=32'h8000_0000, valid=1, pred=0.
   - Required: is_branch=0, mispredict=0.
   - Then BLTZ with the same in1: is_branch=1, mispredict=1, mp_count=1.
3. **Saturation.** 3 consecutive taken BEQ (in1=in2=5) at id_pc=0x40.
   - Required: if_pred_taken at if_pc=0x40 goes 0, then 1 (after the first edge), and stays 1.
   - Then 4 not-taken: counter reaches 00; prediction returns to 0 after 2 of them.
   - Entry for pc=0x140 (aliases idx 16 at depth 64) is identical.
4. **Priority.** Assert exception=1 together with a taken BNE.
   - Required: is_branch=1, mispredict=0, br_count unchanged, BHT unchanged.
   - Same stimulus with id_valid=0: all outputs 0.
5. **Traps and jumps.** TEQ with in1=in2=7: trap_taken=1, is_branch=1. TNE with the same operands: both 0. JR: is_branch=1.
   - Required for all three: no BHT or counter change.
6. **Same-index read/update.** if_pc=id_pc=0x80 with a taken BEQ update.
   - Required: if_pred_taken shows the old value that cycle and the new value the next cycle.
   - With STAT_W=4, 16 branches: br_count wraps to 0.
